// File: rtl/winner_policy_param_if.sv
// Control handshake and node-memory read port of the epsilon-greedy next-hop selector.
interface winner_policy_param_if #(
  parameter int WORD_WIDTH = 16,
  parameter int ADDR_WIDTH = 16
);
  logic                  start;
  logic [1:0]            policy_mode;
  logic                  done;
  logic                  busy;
  logic [WORD_WIDTH-1:0] nexthop;
  logic                  explored;
  logic [ADDR_WIDTH-1:0] address;
  logic [WORD_WIDTH-1:0] data_in;

  modport master (
    output start, policy_mode, data_in,
    input  done, busy, nexthop, explored, address
  );

  modport slave (
    input  start, policy_mode, data_in,
    output done, busy, nexthop, explored, address
  );
endinterface

// File: rtl/winner_policy_param.sv
// Epsilon-greedy next-hop selector: explores a random better-neighbour list entry or
// exploits the best hop against this node's own Q-value, and owns the decaying epsilon.
module winner_policy_param #(
  parameter int                    WORD_WIDTH    = 16,
  parameter int                    ADDR_WIDTH    = 16,
  parameter int                    MAX_NEIGHBORS = 16,
  parameter logic [ADDR_WIDTH-1:0] COUNT_ADDR    = 16'h68C,
  parameter logic [ADDR_WIDTH-1:0] LIST_ADDR     = 16'h668,
  parameter int                    ENTRY_STRIDE  = 2,
  parameter int                    MEM_LATENCY   = 1,
  parameter int                    SCALE_BITS    = 10,
  parameter int                    LO_NUM        = 1023,
  parameter int                    HI_NUM        = 1025,
  parameter int                    EPS_BITS      = 4,
  parameter int                    RNG_BITS      = 16,
  parameter logic [WORD_WIDTH-1:0] NO_HOP        = 100
) (
  input  logic                  clock,
  input  logic                  nreset,
  winner_policy_param_if.slave  bus,
  input  logic [WORD_WIDTH-1:0] mybest,
  input  logic [WORD_WIDTH-1:0] bestvalue,
  input  logic [WORD_WIDTH-1:0] besthop,
  input  logic [WORD_WIDTH-1:0] bestneighbor_id,
  input  logic [WORD_WIDTH-1:0] my_node_id,
  input  logic [EPS_BITS-1:0]   epsilon_init,
  input  logic [EPS_BITS-1:0]   epsilon_step,
  input  logic [EPS_BITS-1:0]   epsilon_min,
  input  logic [RNG_BITS-1:0]   rng_in,
  output logic [EPS_BITS-1:0]   epsilon_out,
  output logic [3:0]            state_out
);

  localparam int CW = $clog2(MAX_NEIGHBORS + 1);
  localparam int PW = WORD_WIDTH + SCALE_BITS + 1;
  localparam int WW = $clog2(MEM_LATENCY + 1);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_DECIDE   = 4'd1,
    S_RD_COUNT = 4'd2,
    S_PICK     = 4'd3,
    S_RD_ENTRY = 4'd4,
    S_CMP_LO   = 4'd5,
    S_CMP_HI   = 4'd6,
    S_DONE     = 4'd7
  } state_t;

  state_t                state;
  logic [WORD_WIDTH-1:0] mybest_q;
  logic [WORD_WIDTH-1:0] bestvalue_q;
  logic [WORD_WIDTH-1:0] besthop_q;
  logic [WORD_WIDTH-1:0] nbr_id_q;
  logic [WORD_WIDTH-1:0] my_id_q;
  logic [CW-1:0]         count_q;
  logic [WW-1:0]         wait_cnt;
  logic [EPS_BITS-1:0]   eps_q;
  logic [WORD_WIDTH-1:0] nexthop_q;
  logic                  explored_q;
  logic [ADDR_WIDTH-1:0] address_q;

  // Threshold bands compared in a widened fixed-point domain so nothing can overflow.
  logic [PW-1:0] scaled_best;
  logic [PW-1:0] lo_bound;
  logic [PW-1:0] hi_bound;

  assign scaled_best = PW'(bestvalue_q) << SCALE_BITS;
  assign lo_bound    = PW'(mybest_q) * PW'(LO_NUM);
  assign hi_bound    = PW'(mybest_q) * PW'(HI_NUM);

  logic explore_now;

  always_comb begin
    case (bus.policy_mode)
      2'd0:    explore_now = rng_in[EPS_BITS-1:0] < eps_q;
      2'd2:    explore_now = 1'b1;
      default: explore_now = 1'b0;
    endcase
  end

  logic [CW-1:0] count_clamped;

  assign count_clamped = (bus.data_in > WORD_WIDTH'(MAX_NEIGHBORS)) ? CW'(MAX_NEIGHBORS)
                                                                    : bus.data_in[CW-1:0];

  // Scaling the random word by count keeps the index in 0..count-1 without a divider.
  logic [RNG_BITS+CW-1:0] pick_prod;
  logic [CW-1:0]          pick_idx;
  logic [31:0]            entry_offset;
  logic [ADDR_WIDTH-1:0]  entry_addr;

  assign pick_prod    = {{CW{1'b0}}, rng_in} * {{RNG_BITS{1'b0}}, count_q};
  assign pick_idx     = pick_prod[RNG_BITS +: CW];
  assign entry_offset = 32'(pick_idx) * 32'(ENTRY_STRIDE);
  assign entry_addr   = LIST_ADDR + entry_offset[ADDR_WIDTH-1:0];

  logic [EPS_BITS-1:0] eps_diff;
  logic [EPS_BITS-1:0] eps_decayed;

  assign eps_diff    = eps_q - epsilon_step;
  assign eps_decayed = (epsilon_step > eps_q || eps_diff < epsilon_min) ? epsilon_min : eps_diff;

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clock) begin
    if (!nreset) begin
      state      <= S_IDLE;
      nexthop_q  <= NO_HOP;
      explored_q <= 1'b0;
      address_q  <= COUNT_ADDR;
      eps_q      <= epsilon_init;
      wait_cnt   <= '0;
      count_q    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            // NOTE: operand latches carry no reset; they are always written before being read.
            mybest_q    <= mybest;
            bestvalue_q <= bestvalue;
            besthop_q   <= besthop;
            nbr_id_q    <= bestneighbor_id;
            my_id_q     <= my_node_id;
            state       <= S_DECIDE;
          end
        end
        S_DECIDE: begin
          wait_cnt <= '0;
          if (explore_now) begin
            address_q <= COUNT_ADDR;
            state     <= S_RD_COUNT;
          end else begin
            state <= S_CMP_LO;
          end
        end
        S_RD_COUNT: begin
          if (wait_cnt == WW'(MEM_LATENCY)) begin
            count_q <= count_clamped;
            state   <= S_PICK;
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
        end
        S_PICK: begin
          wait_cnt <= '0;
          if (count_q == '0) begin
            state <= S_CMP_LO;
          end else begin
            address_q <= entry_addr;
            state     <= S_RD_ENTRY;
          end
        end
        S_RD_ENTRY: begin
          if (wait_cnt == WW'(MEM_LATENCY - 1)) begin
            nexthop_q  <= bus.data_in;
            explored_q <= 1'b1;
            eps_q      <= eps_decayed;
            state      <= S_DONE;
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
        end
        S_CMP_LO: begin
          if (scaled_best < lo_bound) begin
            nexthop_q  <= besthop_q;
            explored_q <= 1'b0;
            state      <= S_DONE;
          end else begin
            state <= S_CMP_HI;
          end
        end
        S_CMP_HI: begin
          nexthop_q  <= (scaled_best < hi_bound && nbr_id_q != my_id_q) ? besthop_q : NO_HOP;
          explored_q <= 1'b0;
          state      <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy     = (state != S_IDLE);
  assign bus.done     = (state == S_DONE);
  assign bus.nexthop  = nexthop_q;
  assign bus.explored = explored_q;
  assign bus.address  = address_q;
  assign epsilon_out  = eps_q;
  assign state_out    = state;

endmodule

// File: tb/tb_winner_policy_param.sv
// Directed bench for winner_policy_param: a transaction-level model predicts each decision
// and a single compare process checks the outputs every cycle against it.
module tb_winner_policy_param;

  localparam int          ML         = 1;
  localparam logic [15:0] COUNT_ADDR = 16'h68C;
  localparam logic [15:0] NO_HOP     = 16'd100;

  logic clock = 1'b0;
  logic nreset = 1'b0;
  always #5 clock = ~clock;

  winner_policy_param_if #(.WORD_WIDTH(16), .ADDR_WIDTH(16)) bus ();

  logic [15:0] mybest, bestvalue, besthop, bestneighbor_id, my_node_id;
  logic [3:0]  epsilon_init, epsilon_step, epsilon_min, epsilon_out;
  logic [15:0] rng_in;
  logic [3:0]  state_out;

  winner_policy_param dut (
    .clock           (clock),
    .nreset          (nreset),
    .bus             (bus),
    .mybest          (mybest),
    .bestvalue       (bestvalue),
    .besthop         (besthop),
    .bestneighbor_id (bestneighbor_id),
    .my_node_id      (my_node_id),
    .epsilon_init    (epsilon_init),
    .epsilon_step    (epsilon_step),
    .epsilon_min     (epsilon_min),
    .rng_in          (rng_in),
    .epsilon_out     (epsilon_out),
    .state_out       (state_out)
  );

  // Node memory: count word plus a 16-entry list at stride 2, read combinationally (latency 1).
  logic [15:0] count_word;
  logic [15:0] list_mem [0:15];
  logic [15:0] mem_data;

  always_comb begin
    mem_data = 16'hDEAD;
    if (bus.address == COUNT_ADDR)
      mem_data = count_word;
    else if (bus.address >= 16'h668 && bus.address < 16'h688)
      mem_data = list_mem[4'((bus.address - 16'h668) >> 1)];
  end
  assign bus.data_in = mem_data;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state (updated by the compare process) and per-operation expectations.
  logic [3:0]  model_eps;
  logic [15:0] model_nh, model_addr;
  logic        model_expl;
  int          exp_lat;
  logic [15:0] exp_nh, exp_addr;
  logic        exp_expl;
  logic [3:0]  exp_eps;
  bit          exp_cnt_path;
  int          op_seq = 0;
  int          done_seq = 0;
  int          done_cyc = 0;

  task automatic model_expect(input logic [1:0] mode);
    int  cnt, idx, e, s, m, extra;
    bit  xpl;
    xpl          = (mode == 2'd2) || (mode == 2'd0 && int'(rng_in[3:0]) < int'(model_eps));
    exp_cnt_path = xpl;
    exp_addr     = model_addr;
    exp_eps      = model_eps;
    exp_expl     = 1'b0;
    extra        = 0;
    if (xpl) begin
      cnt = (count_word > 16) ? 16 : int'(count_word);
      if (cnt > 0) begin
        idx      = (int'(rng_in) * cnt) / 65536;
        exp_nh   = list_mem[idx];
        exp_expl = 1'b1;
        exp_addr = 16'(32'h668 + 2 * idx);
        exp_lat  = 4 + 2 * ML;
        e = int'(model_eps); s = int'(epsilon_step); m = int'(epsilon_min);
        exp_eps  = 4'((s > e) ? m : (((e - s) < m) ? m : (e - s)));
        return;
      end
      exp_addr = COUNT_ADDR;
      extra    = ML + 2;
    end
    if (int'(bestvalue) * 1024 < int'(mybest) * 1023) begin
      exp_nh  = besthop;
      exp_lat = 3 + extra;
    end else begin
      exp_lat = 4 + extra;
      exp_nh  = (int'(bestvalue) * 1024 < int'(mybest) * 1025 && bestneighbor_id != my_node_id)
                ? besthop : NO_HOP;
    end
  endtask

  // Compare process: every cycle, busy/done/held outputs against the model.
  initial begin
    int cyc;
    cyc = 0;
    forever begin
      @(negedge clock);
      if (!nreset) begin
        done_seq   = op_seq;
        cyc        = 0;
        model_eps  = epsilon_init;
        model_nh   = NO_HOP;
        model_expl = 1'b0;
        model_addr = COUNT_ADDR;
      end else if (op_seq != done_seq) begin
        if (cyc == 0) begin
          done_cyc = 0;
        end else begin
          check("busy_active", bus.busy, 1);
          check("done_timing", bus.done, cyc == exp_lat);
          if (bus.done && done_cyc == 0) done_cyc = cyc;
          if (exp_cnt_path && cyc == 2) check("count_addr", bus.address, COUNT_ADDR);
          if (cyc == exp_lat) begin
            check("nexthop", bus.nexthop, exp_nh);
            check("explored", bus.explored, exp_expl);
            check("epsilon", epsilon_out, exp_eps);
            check("address", bus.address, exp_addr);
            model_nh   = exp_nh;
            model_expl = exp_expl;
            model_eps  = exp_eps;
            model_addr = exp_addr;
            done_seq   = op_seq;
          end
        end
        cyc = (op_seq == done_seq) ? 0 : cyc + 1;
      end else begin
        check("idle_busy", bus.busy, 0);
        check("idle_done", bus.done, 0);
        check("idle_eps", epsilon_out, model_eps);
        check("idle_nexthop", bus.nexthop, model_nh);
        check("idle_explored", bus.explored, model_expl);
        check("idle_address", bus.address, model_addr);
      end
    end
  end

  task automatic set_q(input int mb, input int bv, input int bh, input int nid, input int my);
    mybest = 16'(mb); bestvalue = 16'(bv); besthop = 16'(bh);
    bestneighbor_id = 16'(nid); my_node_id = 16'(my);
  endtask

  task automatic run_op(input logic [1:0] mode, input bit hold_in_done);
    bus.policy_mode = mode;
    model_expect(mode);
    @(posedge clock); #2;
    bus.start = 1'b1;
    op_seq++;
    @(posedge clock); #2;
    bus.start = 1'b0;
    if (hold_in_done) begin
      repeat (exp_lat - 1) @(posedge clock);
      #2 bus.start = 1'b1;
      @(posedge clock);
      #2 bus.start = 1'b0;
    end
    for (int i = 0; i < 64; i++) begin
      if (op_seq == done_seq) break;
      @(posedge clock);
    end
    check("op_completed", op_seq == done_seq, 1);
    #2;
  endtask

  task automatic do_reset();
    @(posedge clock); #2 nreset = 1'b0;
    repeat (2) @(posedge clock);
    #2 nreset = 1'b1;
    @(posedge clock); #2;
  endtask

  initial begin
    bit saw_entry;
    bus.start = 1'b0; bus.policy_mode = 2'd1;
    epsilon_init = 4'd8; epsilon_step = 4'd1; epsilon_min = 4'd0;
    rng_in = 16'h0000; count_word = 16'd4;
    for (int i = 0; i < 16; i++) list_mem[i] = 16'(16'h20 + i);
    list_mem[3] = 16'd7; list_mem[15] = 16'h33;
    set_q(1600, 1584, 5, 3, 9);

    do_reset();
    check("rst_state", state_out, 0);
    check("rst_address", bus.address, 16'h68C);
    check("rst_nexthop", bus.nexthop, 100);
    check("rst_eps", epsilon_out, 8);
    check("rst_busy", bus.busy, 0);
    check("rst_explored", bus.explored, 0);

    // Exploit, low band.
    run_op(2'd1, 1'b0);
    check("low_nh", bus.nexthop, 5);
    check("low_lat", done_cyc, 3);
    check("low_eps", epsilon_out, 8);

    // Tie band, then tie band with own ID as neighbour.
    set_q(1600, 1600, 4, 3, 9);
    run_op(2'd1, 1'b0);
    check("tie_nh", bus.nexthop, 4);
    check("tie_lat", done_cyc, 4);
    set_q(1600, 1600, 4, 9, 9);
    run_op(2'd1, 1'b0);
    check("tie_self_nh", bus.nexthop, 100);

    // Explore from the list.
    set_q(1600, 1600, 4, 3, 9);
    rng_in = 16'hC003;
    run_op(2'd0, 1'b0);
    check("xpl_nh", bus.nexthop, 7);
    check("xpl_flag", bus.explored, 1);
    check("xpl_eps", epsilon_out, 7);
    check("xpl_addr", bus.address, 16'h66E);
    check("xpl_lat", done_cyc, 6);

    // Empty list: greedy fallback, low band then tie band.
    count_word = 16'd0;
    set_q(1600, 1584, 11, 3, 9);
    run_op(2'd2, 1'b0);
    check("fb_low_nh", bus.nexthop, 11);
    check("fb_low_lat", done_cyc, ML + 5);
    set_q(1600, 1600, 12, 3, 9);
    run_op(2'd2, 1'b0);
    check("fb_tie_nh", bus.nexthop, 12);
    check("fb_tie_lat", done_cyc, ML + 6);

    // Count clamp with maximal random word.
    count_word = 16'd40;
    rng_in = 16'hFFFF;
    run_op(2'd2, 1'b0);
    check("clamp_addr", bus.address, 16'h686);
    check("clamp_nh", bus.nexthop, 16'h33);

    // Mode 0 without explore; neither band passes.
    rng_in = 16'h000F;
    set_q(1600, 2000, 6, 3, 9);
    run_op(2'd0, 1'b0);
    check("noband_nh", bus.nexthop, 100);
    check("noband_flag", bus.explored, 0);

    // Mode 3 exploits even when the sample would explore.
    rng_in = 16'h0000;
    set_q(1600, 1584, 13, 3, 9);
    run_op(2'd3, 1'b0);
    check("mode3_nh", bus.nexthop, 13);

    // Start held during DONE is ignored.
    set_q(1600, 1584, 5, 3, 9);
    run_op(2'd1, 1'b1);
    @(posedge clock); #2;
    check("hold_state", state_out, 0);
    check("hold_busy", bus.busy, 0);

    // Reset in RD_ENTRY aborts.
    count_word = 16'd4;
    rng_in = 16'hC003;
    bus.policy_mode = 2'd2;
    model_expect(2'd2);
    @(posedge clock); #2;
    bus.start = 1'b1;
    op_seq++;
    @(posedge clock); #2;
    bus.start = 1'b0;
    saw_entry = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (state_out == 4'd4) begin saw_entry = 1'b1; break; end
      @(posedge clock); #2;
    end
    check("abort_reached_entry", saw_entry, 1);
    nreset = 1'b0;
    @(posedge clock); #2;
    @(posedge clock); #2 nreset = 1'b1;
    @(posedge clock); #2;
    check("abort_done", bus.done, 0);
    check("abort_nh", bus.nexthop, 100);
    check("abort_eps", epsilon_out, 8);

    // Epsilon floor.
    epsilon_init = 4'd1; epsilon_step = 4'd2; epsilon_min = 4'd0;
    do_reset();
    run_op(2'd2, 1'b0);
    check("floor_eps1", epsilon_out, 0);
    run_op(2'd2, 1'b0);
    check("floor_eps2", epsilon_out, 0);
    rng_in = 16'h0000;
    set_q(1600, 1584, 5, 3, 9);
    run_op(2'd0, 1'b0);
    check("floor_no_explore", bus.explored, 0);
    check("floor_nh", bus.nexthop, 5);

    repeat (2) @(posedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
